// File: rtl/vram_burst_engine.sv
// VRAM burst sequencer: one write burst per vsync rising edge, one read burst at pixel (0,0).
// Optional readback shadow check enabled by defining VRAM_READBACK_CHECK_EN.
module vram_burst_engine #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int WR_LEN  = 4,
  parameter int RD_LEN  = 4,
  parameter int WR_BASE = 0,
  parameter int RD_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vs,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [7:0]        src_idx,
  input  logic [DATA_W-1:0] src_data,
  input  logic              wr_full,
  input  logic              rd_empty,
  input  logic [DATA_W-1:0] readdata,
  output logic              write,
  output logic [ADDR_W-1:0] writeaddr,
  output logic [DATA_W-1:0] writedata,
  output logic              read,
  output logic [ADDR_W-1:0] readaddr,
  output logic [DATA_W-1:0] rd_data,
  output logic [7:0]        rd_idx,
  output logic              rd_valid,
  output logic              busy,
  output logic              wr_done,
  output logic              rd_done,
  output logic              overrun,
  output logic              mismatch
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_WAIT = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;

  localparam logic [7:0]        WR_LAST   = 8'(WR_LEN - 1);
  localparam logic [7:0]        RD_LAST   = 8'(RD_LEN - 1);
  localparam logic [ADDR_W-1:0] WR_BASE_A = ADDR_W'(WR_BASE);
  localparam logic [ADDR_W-1:0] RD_BASE_A = ADDR_W'(RD_BASE);

  logic [2:0] state;
  logic [7:0] cnt;
  logic       vs_q;
  logic       pix0_q;
  logic       pix0;
  logic       wr_req;
  logic       rd_req;

  assign pix0   = (DrawX == '0) && (DrawY == '0);
  assign wr_req = vs & ~vs_q;
  assign rd_req = pix0 & ~pix0_q;

  // Request-side outputs are forced to zero outside their state so idle outputs read as 0.
  always_comb begin
    write     = (state == S_WR_REQ);
    read      = (state == S_RD_REQ);
    busy      = (state != S_IDLE);
    src_idx   = write ? cnt : '0;
    writeaddr = write ? WR_BASE_A + ADDR_W'(cnt) : '0;
    writedata = write ? src_data : '0;
    readaddr  = read ? RD_BASE_A + ADDR_W'(cnt) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      vs_q     <= 1'b0;
      pix0_q   <= 1'b0;
      rd_data  <= '0;
      rd_idx   <= '0;
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      vs_q     <= vs;
      pix0_q   <= pix0;
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
      if ((state != S_IDLE) && (wr_req || rd_req))
        overrun <= 1'b1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (wr_req)      state <= S_WR_REQ;
          else if (rd_req) state <= S_RD_REQ;
        end
        S_WR_REQ: state <= S_WR_WAIT;
        S_WR_WAIT: begin
          if (!wr_full) begin
            if (cnt == WR_LAST) begin
              state   <= S_IDLE;
              wr_done <= 1'b1;
            end else begin
              cnt   <= cnt + 8'd1;
              state <= S_WR_REQ;
            end
          end
        end
        S_RD_REQ: state <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (!rd_empty) begin
            rd_data  <= readdata;
            rd_idx   <= cnt;
            rd_valid <= 1'b1;
            if (cnt == RD_LAST) begin
              state   <= S_IDLE;
              rd_done <= 1'b1;
            end else begin
              cnt   <= cnt + 8'd1;
              state <= S_RD_REQ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef VRAM_READBACK_CHECK_EN
  localparam int SH_W = (WR_LEN > 1) ? $clog2(WR_LEN) : 1;

  logic [DATA_W-1:0] shadow [WR_LEN];
  logic              in_shadow;

  assign in_shadow = ({1'b0, cnt} < 9'(WR_LEN));

  // Shadow contents survive reset; only the sticky flag is cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch <= 1'b0;
    end else begin
      if (write && in_shadow)
        shadow[cnt[SH_W-1:0]] <= src_data;
      if ((state == S_RD_WAIT) && !rd_empty && in_shadow &&
          (readdata != shadow[cnt[SH_W-1:0]]))
        mismatch <= 1'b1;
    end
  end
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_vram_burst_engine.sv
// Self-checking bench for vram_burst_engine: default instance plus a wrap-around WR_BASE instance.
module tb_vram_burst_engine;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int WR_LEN = 4;
  localparam int RD_LEN = 4;
`ifdef VRAM_READBACK_CHECK_EN
  localparam bit MM_EN = 1'b1;
`else
  localparam bit MM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1, vs = 1'b0, wr_full = 1'b0, rd_empty = 1'b1;
  logic [9:0]        DrawX = 10'd5, DrawY = 10'd5;
  logic [7:0]        src_idx, rd_idx;
  logic [DATA_W-1:0] src_data, readdata = '0, writedata, rd_data;
  logic [ADDR_W-1:0] writeaddr, readaddr;
  logic write, read, rd_valid, busy, wr_done, rd_done, overrun, mismatch;

  logic              reset2 = 1'b1, vs2 = 1'b0;
  logic [7:0]        src_idx2, rd_idx2;
  logic [DATA_W-1:0] src_data2, writedata2, rd_data2;
  logic [ADDR_W-1:0] writeaddr2, readaddr2;
  logic write2, read2, rd_valid2, busy2, wr_done2, rd_done2, overrun2, mismatch2;

  logic [DATA_W-1:0] src_mem  [256];
  logic [DATA_W-1:0] rd_mem   [256];
  logic [DATA_W-1:0] shadow_m [WR_LEN];
  bit                mm_m = 1'b0;
  int                wr_times [WR_LEN];
  int                done_time;
  int                checks = 0;
  int                failures = 0;

  assign src_data  = src_mem[src_idx];
  assign src_data2 = src_mem[src_idx2];

  vram_burst_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_LEN(WR_LEN), .RD_LEN(RD_LEN),
                      .WR_BASE(0), .RD_BASE(0)) dut (
    .clk(clk), .reset(reset), .vs(vs), .DrawX(DrawX), .DrawY(DrawY),
    .src_idx(src_idx), .src_data(src_data), .wr_full(wr_full), .rd_empty(rd_empty),
    .readdata(readdata), .write(write), .writeaddr(writeaddr), .writedata(writedata),
    .read(read), .readaddr(readaddr), .rd_data(rd_data), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .busy(busy), .wr_done(wr_done), .rd_done(rd_done),
    .overrun(overrun), .mismatch(mismatch));

  vram_burst_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_LEN(WR_LEN), .RD_LEN(RD_LEN),
                      .WR_BASE(16'hFFFE), .RD_BASE(0)) dut2 (
    .clk(clk), .reset(reset2), .vs(vs2), .DrawX(10'd1), .DrawY(10'd1),
    .src_idx(src_idx2), .src_data(src_data2), .wr_full(1'b0), .rd_empty(1'b1),
    .readdata(16'h0000), .write(write2), .writeaddr(writeaddr2), .writedata(writedata2),
    .read(read2), .readaddr(readaddr2), .rd_data(rd_data2), .rd_idx(rd_idx2),
    .rd_valid(rd_valid2), .busy(busy2), .wr_done(wr_done2), .rd_done(rd_done2),
    .overrun(overrun2), .mismatch(mismatch2));

  task automatic do_reset();
    reset = 1'b1; vs = 1'b0; wr_full = 1'b0; rd_empty = 1'b1; DrawX = 10'd5; DrawY = 10'd5;
    @(negedge clk); @(negedge clk);
    reset = 1'b0; mm_m = 1'b0;
  endtask

  // Drives one vsync edge and follows the burst: each word is a write followed by at
  // least one wait cycle; a wait cycle with wr_full low makes the next word (or done) due.
  // mode 0: no back-pressure, 1: random wr_full, 2: wr_full for 5 cycles after word 2.
  task automatic wr_burst(input int mode, input bit also_pix, input bit mid_edge);
    int due, nxt_due, exp_idx, cyc, full_left;
    bit wait_now, nxt_wait, fin;
    due = 1; exp_idx = 0; cyc = 0; full_left = 0; wait_now = 0; fin = 0;
    vs = 1'b1;
    if (also_pix) begin DrawX = 10'd0; DrawY = 10'd0; end
    while (!fin && cyc < 300) begin
      @(negedge clk); cyc++;
      checks++;
      if (write !== (due == 1)) begin failures++; $display("FAIL wr_write cyc=%0d got=%b want=%b", cyc, write, due == 1); end
      if (due == 1 && write === 1'b1) begin
        checks++;
        if (writeaddr !== 16'(exp_idx)) begin failures++; $display("FAIL wr_addr got=%h want=%h", writeaddr, 16'(exp_idx)); end
        checks++;
        if (writedata !== src_mem[exp_idx]) begin failures++; $display("FAIL wr_data got=%h want=%h", writedata, src_mem[exp_idx]); end
        wr_times[exp_idx] = cyc;
        shadow_m[exp_idx] = src_mem[exp_idx];
      end
      checks++;
      if (wr_done !== (due == 2)) begin failures++; $display("FAIL wr_done cyc=%0d got=%b want=%b", cyc, wr_done, due == 2); end
      checks++;
      if (busy !== (due != 2)) begin failures++; $display("FAIL wr_busy cyc=%0d got=%b want=%b", cyc, busy, due != 2); end
      checks++;
      if (read !== 1'b0) begin failures++; $display("FAIL wr_no_read got=%b want=0", read); end
      if (due == 2) begin fin = 1; done_time = cyc; end
      if (mode == 1)                         wr_full = ($urandom_range(0, 99) < 40);
      else if (mode == 2 && full_left > 0) begin wr_full = 1'b1; full_left--; end
      else                                   wr_full = 1'b0;
      if (mid_edge && cyc == 3) vs = 1'b0;
      if (mid_edge && cyc == 4) vs = 1'b1;
      nxt_due = 0; nxt_wait = 0;
      if (due == 1) begin
        exp_idx++; nxt_wait = 1;
        if (mode == 2 && exp_idx == 2) full_left = 5;
      end
      if (wait_now) begin
        if (!wr_full) nxt_due = (exp_idx == WR_LEN) ? 2 : 1;
        else          nxt_wait = 1;
      end
      due = nxt_due; wait_now = nxt_wait;
    end
    if (!fin) begin failures++; $display("FAIL wr_timeout got=no_done want=done"); end
    wr_full = 1'b0; DrawX = 10'd5; DrawY = 10'd5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (write !== 1'b0 || busy !== 1'b0 || read !== 1'b0) begin
        failures++; $display("FAIL wr_idle_hold got=w%b b%b r%b want=000", write, busy, read);
      end
    end
    vs = 1'b0;
    @(negedge clk);
  endtask

  // Read burst from pixel (0,0); readdata follows the last issued readaddr.
  task automatic rd_burst(input bit rand_empty);
    int due, nxt_due, exp_idx, cyc, val_idx, nxt_val_idx;
    bit wait_now, nxt_wait, fin, val_due, nxt_val;
    due = 1; exp_idx = 0; cyc = 0; wait_now = 0; fin = 0; val_due = 0; val_idx = 0;
    DrawX = 10'd0; DrawY = 10'd0;
    while (!fin && cyc < 300) begin
      @(negedge clk); cyc++;
      checks++;
      if (read !== (due == 1)) begin failures++; $display("FAIL rd_read cyc=%0d got=%b want=%b", cyc, read, due == 1); end
      if (due == 1 && read === 1'b1) begin
        checks++;
        if (readaddr !== 16'(exp_idx)) begin failures++; $display("FAIL rd_addr got=%h want=%h", readaddr, 16'(exp_idx)); end
      end
      checks++;
      if (rd_valid !== val_due) begin failures++; $display("FAIL rd_valid cyc=%0d got=%b want=%b", cyc, rd_valid, val_due); end
      if (val_due) begin
        checks++;
        if (rd_data !== rd_mem[val_idx]) begin failures++; $display("FAIL rd_data got=%h want=%h", rd_data, rd_mem[val_idx]); end
        checks++;
        if (rd_idx !== 8'(val_idx)) begin failures++; $display("FAIL rd_idx got=%0d want=%0d", rd_idx, val_idx); end
        if (MM_EN && val_idx < WR_LEN && rd_mem[val_idx] !== shadow_m[val_idx]) mm_m = 1'b1;
      end
      checks++;
      if (mismatch !== mm_m) begin failures++; $display("FAIL rd_mismatch cyc=%0d got=%b want=%b", cyc, mismatch, mm_m); end
      checks++;
      if (rd_done !== (due == 2)) begin failures++; $display("FAIL rd_done cyc=%0d got=%b want=%b", cyc, rd_done, due == 2); end
      checks++;
      if (busy !== (due != 2) || write !== 1'b0) begin
        failures++; $display("FAIL rd_busy cyc=%0d got=b%b w%b want=b%b w0", cyc, busy, write, due != 2);
      end
      if (due == 2) fin = 1;
      if (read === 1'b1) readdata = rd_mem[readaddr[7:0]];
      rd_empty = rand_empty ? ($urandom_range(0, 99) < 40) : 1'b0;
      nxt_due = 0; nxt_wait = 0; nxt_val = 0; nxt_val_idx = 0;
      if (due == 1) nxt_wait = 1;
      if (wait_now) begin
        if (!rd_empty) begin
          nxt_val = 1; nxt_val_idx = exp_idx;
          nxt_due = (exp_idx == RD_LEN - 1) ? 2 : 1;
          exp_idx++;
        end else nxt_wait = 1;
      end
      due = nxt_due; wait_now = nxt_wait; val_due = nxt_val; val_idx = nxt_val_idx;
    end
    if (!fin) begin failures++; $display("FAIL rd_timeout got=no_done want=done"); end
    rd_empty = 1'b1; DrawX = 10'd5; DrawY = 10'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (read !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rd_idle got=r%b b%b want=00", read, busy); end
    end
  endtask

  task automatic test_reset();
    do_reset();
    reset2 = 1'b1; @(negedge clk); reset2 = 1'b0;
    checks++;
    if ({write, read, busy, rd_valid, wr_done, rd_done, overrun, mismatch} !== 8'h00) begin
      failures++; $display("FAIL reset_flags got=%b want=00000000", {write, read, busy, rd_valid, wr_done, rd_done, overrun, mismatch});
    end
    checks++;
    if ({writeaddr, writedata, readaddr, rd_data, rd_idx, src_idx} !== '0) begin
      failures++; $display("FAIL reset_buses got=%h/%h/%h/%h/%h/%h want=0", writeaddr, writedata, readaddr, rd_data, rd_idx, src_idx);
    end
    checks++;
    if ({write2, read2, busy2, wr_done2, overrun2, mismatch2, writeaddr2} !== '0) begin
      failures++; $display("FAIL reset_dut2 got=%b%b%b%b%b%b addr=%h want=0", write2, read2, busy2, wr_done2, overrun2, mismatch2, writeaddr2);
    end
  endtask

  task automatic test_write_basic();
    for (int i = 0; i < 256; i++) src_mem[i] = 16'(i);
    wr_burst(0, 1'b0, 1'b0);
    checks++;
    if (done_time - wr_times[0] != 8) begin failures++; $display("FAIL wr_latency got=%0d want=8", done_time - wr_times[0]); end
    for (int i = 1; i < WR_LEN; i++) begin
      checks++;
      if (wr_times[i] - wr_times[i-1] != 2) begin failures++; $display("FAIL wr_spacing got=%0d want=2", wr_times[i] - wr_times[i-1]); end
    end
  endtask

  task automatic test_write_stall();
    for (int i = 0; i < 256; i++) src_mem[i] = 16'(16'h0100 + i);
    wr_burst(2, 1'b0, 1'b0);
    checks++;
    if (wr_times[2] - wr_times[1] != 7) begin failures++; $display("FAIL wr_stall_gap got=%0d want=7", wr_times[2] - wr_times[1]); end
  endtask

  task automatic test_read_basic();
    for (int i = 0; i < 256; i++) rd_mem[i] = 16'(16'h00A0 + i);
    rd_burst(1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) src_mem[i] = 16'($urandom);
      wr_burst(1, 1'b0, 1'b0);
      for (int i = 0; i < 256; i++) rd_mem[i] = 16'($urandom);
      if ($urandom_range(0, 1) == 1) for (int i = 0; i < WR_LEN; i++) rd_mem[i] = shadow_m[i];
      rd_burst(1'b1);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr_burst(0, 1'b1, 1'b0);
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL simul_overrun got=%b want=0", overrun); end
    wr_burst(0, 1'b0, 1'b1);
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL mid_overrun got=%b want=1", overrun); end
  endtask

  task automatic test_readback();
    do_reset();
    for (int i = 0; i < 256; i++) begin src_mem[i] = 16'(i); rd_mem[i] = 16'(i); end
    rd_mem[2] = 16'h0007;
    wr_burst(0, 1'b0, 1'b0);
    rd_burst(1'b0);
    checks++;
    if (mismatch !== MM_EN) begin failures++; $display("FAIL readback_mismatch got=%b want=%b", mismatch, MM_EN); end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_a;
    int n, nd;
    n = 0; nd = 0;
    reset2 = 1'b1; @(negedge clk); reset2 = 1'b0;
    vs2 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (write2 === 1'b1) begin
        exp_a = 16'hFFFE + 16'(n);
        checks++;
        if (writeaddr2 !== exp_a) begin failures++; $display("FAIL wrap_addr got=%h want=%h", writeaddr2, exp_a); end
        checks++;
        if (writedata2 !== src_mem[n & 255]) begin failures++; $display("FAIL wrap_data got=%h want=%h", writedata2, src_mem[n & 255]); end
        n++;
      end
      if (wr_done2 === 1'b1) nd++;
    end
    checks++;
    if (n != WR_LEN || nd != 1) begin failures++; $display("FAIL wrap_count got=%0d/%0d want=%0d/1", n, nd, WR_LEN); end
    vs2 = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int n, c;
    n = 0; c = 0;
    @(negedge clk); vs2 = 1'b1;
    while (n < 2 && c < 20) begin
      @(negedge clk); c++;
      if (write2 === 1'b1) n++;
    end
    checks++;
    if (n != 2) begin failures++; $display("FAIL rst_mid_find got=%0d want=2", n); end
    @(negedge clk);
    reset2 = 1'b1; vs2 = 1'b0;
    @(negedge clk);
    checks++;
    if ({write2, read2, busy2, wr_done2, rd_valid2, overrun2, writeaddr2, writedata2, src_idx2} !== '0) begin
      failures++; $display("FAIL rst_mid_zero got=%b%b%b%b%b%b a=%h d=%h i=%h want=0", write2, read2, busy2, wr_done2, rd_valid2, overrun2, writeaddr2, writedata2, src_idx2);
    end
    reset2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (write2 !== 1'b0 || wr_done2 !== 1'b0 || busy2 !== 1'b0) begin
        failures++; $display("FAIL rst_mid_quiet got=w%b d%b b%b want=000", write2, wr_done2, busy2);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin src_mem[i] = '0; rd_mem[i] = '0; end
    test_reset();
    test_write_basic();
    test_write_stall();
    test_read_basic();
    test_random();
    test_back_to_back();
    test_readback();
    test_wrap();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
